// File: rtl/dram_lsu_if.sv
// Bundle between the core's memory stage, the load/store unit and the data DRAM.
// The slave modport is the LSU's view; the master modport is the core/DRAM side.
interface dram_lsu_if #(
   parameter int ADDR_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_err;
   logic [31:0]       rsp_rdata;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_we;
   logic [31:0]       mem_din;
   logic [31:0]       mem_spo;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_spo,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_a, mem_we, mem_din
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_spo,
      output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_a, mem_we, mem_din
   );
endinterface

// File: rtl/dram_lsu.sv
// Load/store unit turning RISC-V byte/half/word accesses into word DRAM cycles,
// with read-modify-write for sub-word stores since the DRAM has no byte enables.
module dram_lsu #(
   parameter int ADDR_W = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   dram_lsu_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RD_WAIT,
      S_WR,
      S_RESP
   } state_t;

   state_t            r_state;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [ADDR_W+1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_err;
   logic [31:0]       r_rdata;

   logic        w_xfer;
   logic        w_req_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;
   logic [3:0]  w_lane_en;
   logic        w_unused;

   // Upper address bits alias onto the DRAM and are deliberately dropped.
   assign w_unused = ^bus.req_addr[31:ADDR_W+2];

   assign w_xfer = bus.req_valid && (r_state == S_IDLE);

   always_comb begin
      w_req_err = 1'b1;
      case (bus.req_funct3)
         3'd0:    w_req_err = 1'b0;
         3'd1:    w_req_err = bus.req_addr[0];
         3'd2:    w_req_err = |bus.req_addr[1:0];
         3'd4:    w_req_err = bus.req_we;
         3'd5:    w_req_err = bus.req_we | bus.req_addr[0];
         default: w_req_err = 1'b1;
      endcase
   end

   assign w_byte = bus.mem_spo[{r_addr[1:0], 3'b000} +: 8];
   assign w_half = r_addr[1] ? bus.mem_spo[31:16] : bus.mem_spo[15:0];

   always_comb begin
      w_load_data = bus.mem_spo;
      case (r_funct3)
         3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
         3'd4:    w_load_data = {24'h0, w_byte};
         3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
         3'd5:    w_load_data = {16'h0, w_half};
         default: w_load_data = bus.mem_spo;
      endcase
   end

   // funct3[0] distinguishes SH (halfword lanes) from SB (single byte lane).
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign w_lane_en[gi] = r_funct3[0] ? (r_addr[1] == LANE[1])
                                            : (r_addr[1:0] == LANE);
         assign w_merged[8*gi +: 8] = !w_lane_en[gi] ? bus.mem_spo[8*gi +: 8]
                                    : r_funct3[0]    ? r_wdata[8*(gi%2) +: 8]
                                    :                  r_wdata[7:0];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_we     <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= '0;
         r_wdata  <= 32'h0;
         r_err    <= 1'b0;
         r_rdata  <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_we     <= bus.req_we;
                  r_funct3 <= bus.req_funct3;
                  r_addr   <= bus.req_addr[ADDR_W+1:0];
                  r_wdata  <= bus.req_wdata;
                  r_err    <= w_req_err;
                  r_rdata  <= 32'h0;
                  if (w_req_err)
                     r_state <= S_RESP;
                  else if (bus.req_we && bus.req_funct3 == 3'd2)
                     r_state <= S_WR;
                  else
                     r_state <= S_RD;
               end
            end
            S_RD:      r_state <= S_RD_WAIT;
            S_RD_WAIT: begin
               // The merged word replaces the store data so WR always writes r_wdata.
               if (r_we) begin
                  r_wdata <= w_merged;
                  r_state <= S_WR;
               end else begin
                  r_rdata <= w_load_data;
                  r_state <= S_RESP;
               end
            end
            S_WR:      r_state <= S_RESP;
            S_RESP:    r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_err   = r_err;
   assign bus.rsp_rdata = r_rdata;
   assign bus.mem_a     = r_addr[ADDR_W+1:2];
   assign bus.mem_we    = (r_state == S_WR);
   assign bus.mem_din   = (r_state == S_WR) ? r_wdata : 32'h0;
endmodule

// File: tb/tb_dram_lsu.sv
// Bench for dram_lsu: byte-level memory reference model feeding a scoreboard queue,
// a monitor checking responses, latencies, DRAM writes and req_ready every cycle.
`timescale 1ns/1ps
module tb_dram_lsu;
   localparam int          ADDR_W = 16;
   localparam logic [31:0] AMASK  = 32'h0003_FFFF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   dram_lsu_if #(.ADDR_W(ADDR_W)) bus ();
   dram_lsu #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cycle   = 0;
   int n_rsp   = 0;

   always @(posedge clk) cycle <= cycle + 1;

   // DRAM: synchronous read-first word memory, not affected by reset.
   logic [31:0] dram [int unsigned];
   always @(posedge clk) begin
      int unsigned idx;
      idx = 32'(bus.mem_a);
      bus.mem_spo <= dram.exists(idx) ? dram[idx] : 32'h0;
      if (bus.mem_we) dram[idx] = bus.mem_din;
   end

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          writes;
      logic [15:0] wa;
      logic [31:0] wd;
   } exp_t;

   exp_t exp_q[$];
   byte unsigned ref_mem [int unsigned];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cycle);
      end
   endtask

   task automatic flag(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cycle);
   endtask

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      int unsigned k;
      k = a & AMASK;
      return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
   endfunction

   // Reference behaviour from the ISA rules: byte-addressed memory, size from funct3.
   function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input bit apply);
      exp_t        e;
      int          size;
      int          off;
      bit          legal;
      logic [31:0] base;
      logic [31:0] v;
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      e.err    = !legal || (a % size != 0);
      e.rdata  = 32'h0;
      e.lat    = 1;
      e.writes = 0;
      e.wa     = a[17:2];
      e.wd     = 32'h0;
      if (e.err) return e;
      if (we) begin
         base = a & ~32'h3;
         off  = int'(a % 4);
         for (int k = 0; k < 4; k++) begin
            if (k >= off && k < off + size) begin
               e.wd[8*k +: 8] = wd[8*(k-off) +: 8];
               if (apply) ref_mem[(base + k) & AMASK] = wd[8*(k-off) +: 8];
            end else begin
               e.wd[8*k +: 8] = rd_byte(base + k);
            end
         end
         e.writes = 1;
         e.lat    = (size == 4) ? 2 : 4;
      end else begin
         v = 32'h0;
         for (int i = 0; i < size; i++) v[8*i +: 8] = rd_byte(a + i);
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
         e.rdata = v;
         e.lat   = 3;
      end
      return e;
   endfunction

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit apply, input bit keep,
                        output int tcyc);
      exp_t e;
      int   k;
      e = model(we, f3, a, wd, apply);
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      bus.req_valid  = 1'b1;
      k = 0;
      @(negedge clk);
      while (!bus.req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      tcyc = cycle;
      if (!bus.req_ready) begin
         flag("req_ready timeout");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (!keep) bus.req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         flag("response timeout");
         exp_q.delete();
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " mem_we"},    32'(bus.mem_we),    32'h0);
      chk({tag, " mem_a"},     32'(bus.mem_a),     32'h0);
      chk({tag, " mem_din"},   bus.mem_din,        32'h0);
      chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
      chk({tag, " rsp_err"},   32'(bus.rsp_err),   32'h0);
      chk({tag, " rsp_rdata"}, bus.rsp_rdata,      32'h0);
      chk({tag, " req_ready"}, 32'(bus.req_ready), 32'h1);
   endtask

   // Monitor: protocol-level checks, decoupled from the stimulus process.
   initial begin : monitor
      bit   busy;
      int   tcyc;
      int   wcnt;
      exp_t e;
      busy = 0;
      tcyc = 0;
      wcnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 0;
            wcnt = 0;
         end else begin
            chk("req_ready", 32'(bus.req_ready), 32'(!busy));
            if (!bus.mem_we) chk("mem_din idle", bus.mem_din, 32'h0);
            if (bus.mem_we) begin
               wcnt++;
               if (exp_q.size() > 0) begin
                  chk("mem_a on write", 32'(bus.mem_a), 32'(exp_q[0].wa));
                  chk("mem_din on write", bus.mem_din, exp_q[0].wd);
               end else begin
                  flag("unexpected mem_we");
               end
            end
            if (bus.rsp_valid) begin
               if (busy && exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  n_rsp++;
                  $display("[TB] rsp %0d: err=%0b rdata=0x%08h latency=%0d writes=%0d",
                           n_rsp, bus.rsp_err, bus.rsp_rdata, cycle - tcyc, wcnt);
                  chk("rsp_err",   32'(bus.rsp_err), 32'(e.err));
                  chk("rsp_rdata", bus.rsp_rdata,    e.rdata);
                  chk("latency",   32'(cycle - tcyc), 32'(e.lat));
                  chk("write count", 32'(wcnt), 32'(e.writes));
               end else begin
                  flag("unexpected rsp_valid");
               end
               busy = 0;
            end
            if (bus.req_valid && bus.req_ready) begin
               busy = 1;
               tcyc = cycle;
               wcnt = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          t1;
      int          t2;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      issue(1'b1, 3'd2, 32'h40, 32'h80FF7F01, 1, 0, t1); wait_done();
      issue(1'b0, 3'd0, 32'h41, 32'h0, 1, 0, t1); wait_done();
      issue(1'b0, 3'd0, 32'h42, 32'h0, 1, 0, t1); wait_done();
      issue(1'b0, 3'd4, 32'h42, 32'h0, 1, 0, t1); wait_done();
      issue(1'b0, 3'd1, 32'h42, 32'h0, 1, 0, t1); wait_done();
      issue(1'b0, 3'd5, 32'h42, 32'h0, 1, 0, t1); wait_done();
      issue(1'b0, 3'd2, 32'h40, 32'h0, 1, 0, t1); wait_done();

      issue(1'b1, 3'd0, 32'h43, 32'h000000AB, 1, 0, t1); wait_done();
      issue(1'b1, 3'd1, 32'h40, 32'h00001234, 1, 0, t1); wait_done();
      issue(1'b0, 3'd2, 32'h40, 32'h0, 1, 0, t1); wait_done();

      issue(1'b0, 3'd2, 32'h42, 32'h0, 1, 0, t1); wait_done();
      issue(1'b1, 3'd1, 32'h41, 32'hFFFF_FFFF, 1, 0, t1); wait_done();
      issue(1'b0, 3'd3, 32'h40, 32'h0, 1, 0, t1); wait_done();
      issue(1'b0, 3'd2, 32'h40, 32'h0, 1, 0, t1); wait_done();

      // Sub-word store aborted by reset while its read data is on mem_spo.
      issue(1'b1, 3'd0, 32'h40, 32'h00000055, 0, 0, t1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      void'(exp_q.pop_front());
      #1;
      chk("abort mem_we", 32'(bus.mem_we), 32'h0);
      chk("abort rsp_valid", 32'(bus.rsp_valid), 32'h0);
      repeat (3) @(negedge clk);
      chk_reset_vals("abort");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_vals("post-abort");
      issue(1'b0, 3'd2, 32'h40, 32'h0, 1, 0, t1); wait_done();

      // Back-to-back with req_valid held high.
      issue(1'b0, 3'd2, 32'h40, 32'h0, 1, 1, t1);
      issue(1'b1, 3'd2, 32'h44, $urandom, 1, 0, t2);
      chk("b2b transfer cycle", 32'(t2), 32'(t1 + 4));
      wait_done();
      issue(1'b0, 3'd2, 32'h44, 32'h0, 1, 0, t1); wait_done();

      for (int n = 0; n < 400; n++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = ($urandom & 32'hFFFC_0000) | (32'h100 + 32'($urandom_range(0, 31)));
         issue(we, f3, a, $urandom, 1, 0, t1);
         wait_done();
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
